// File: rtl/snap_ring_capture.sv
// snap_ring_capture: circular wide-sample capture buffer with pre-trigger depth and oldest-first narrow CPU readout
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   din, din_valid        DATA_W capture stream and its write strobe
//   arm                   pulse that restarts a capture and latches pretrig_len
//   trig                  level trigger, honoured only together with din_valid
//   pretrig_len           samples kept ahead of the trigger sample
//   rd_en, rd_addr        CPU word read, word 0 = LS lane of the oldest sample
//   rd_data, rd_valid     read result, two cycles after rd_en
//   busy, done            capture in progress / capture complete
//   trig_addr             physical buffer address of the trigger sample
//   trig_time             (only with SNAP_TRIG_TIME_EN) cycle count at the trigger
module snap_ring_capture #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 10,
  parameter int RD_W   = 32
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [DATA_W-1:0]                        din,
  input  logic                                     din_valid,
  input  logic                                     arm,
  input  logic                                     trig,
  input  logic [ADDR_W-1:0]                        pretrig_len,
  input  logic                                     rd_en,
  input  logic [ADDR_W+$clog2(DATA_W/RD_W)-1:0]    rd_addr,
  output logic [RD_W-1:0]                          rd_data,
  output logic                                     rd_valid,
  output logic                                     busy,
  output logic                                     done,
  output logic [ADDR_W-1:0]                        trig_addr
`ifdef SNAP_TRIG_TIME_EN
  ,
  output logic [31:0]                              trig_time
`endif
);
  localparam int RATIO = DATA_W / RD_W;
  localparam int LR    = $clog2(RATIO);
  localparam int LW    = (LR == 0) ? 1 : LR;
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_t;
  state_t                          state_q, state_d;
  logic [ADDR_W-1:0]               wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]               cnt_q, cnt_d;
  logic [ADDR_W-1:0]               p_q, p_d;
  logic [ADDR_W-1:0]               trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]               start_addr_q, start_addr_d;
  logic                            we, fire;
  logic [RATIO-1:0][RD_W-1:0]      mem [DEPTH];
  logic [RATIO-1:0][RD_W-1:0]      ram_q;
  logic [ADDR_W-1:0]               rd_phys;
  logic [LW-1:0]                   lane_q, lane_d;
  logic                            v1_q, v1_d;
  logic [RD_W-1:0]                 rd_data_q, rd_data_d;
  logic                            rd_valid_q, rd_valid_d;
  // cnt_q counts pre-trigger writes in PRE and remaining writes in POST
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    p_d          = p_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    we           = 1'b0;
    fire         = 1'b0;
    if (arm) begin
      state_d  = PRE;
      wr_ptr_d = '0;
      cnt_d    = '0;
      p_d      = pretrig_len;
    end else begin
      case (state_q)
        PRE: begin
          we = din_valid;
          if (p_q == '0) state_d = WAIT_TRIG;
          else if (din_valid) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == p_q) state_d = WAIT_TRIG;
          end
        end
        WAIT_TRIG: begin
          we = din_valid;
          if (din_valid && trig) begin
            fire         = 1'b1;
            trig_addr_d  = wr_ptr_q;
            start_addr_d = wr_ptr_q - p_q;
            cnt_d        = ~p_q;
            state_d      = (&p_q) ? DONE : POST;
          end
        end
        POST: begin
          we = din_valid;
          if (din_valid) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == ADDR_W'(1)) state_d = DONE;
          end
        end
        default: ;
      endcase
      if (we) wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      p_q          <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      p_q          <= p_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
    end
  end
  // Reads are rotated so that sample index 0 is the oldest retained sample
  always_comb begin
    rd_phys    = start_addr_q + ADDR_W'(rd_addr >> LR);
    lane_d     = LW'(rd_addr) & LW'(RATIO - 1);
    v1_d       = rd_en;
    rd_data_d  = ram_q[lane_q];
    rd_valid_d = v1_q;
  end
  // Buffer storage is never cleared; writes are suppressed while in reset
  always_ff @(posedge clk) begin
    if (we && rst_n) mem[wr_ptr_q] <= din;
    ram_q <= mem[rd_phys];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q     <= '0;
      v1_q       <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      v1_q       <= v1_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
`ifdef SNAP_TRIG_TIME_EN
  logic [31:0] cyc_q, cyc_d, trig_time_q, trig_time_d;
  always_comb begin
    cyc_d       = cyc_q + 32'd1;
    trig_time_d = fire ? cyc_q : trig_time_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q       <= '0;
      trig_time_q <= '0;
    end else begin
      cyc_q       <= cyc_d;
      trig_time_q <= trig_time_d;
    end
  end
  assign trig_time = trig_time_q;
`else
  logic unused_fire;
  assign unused_fire = fire;
`endif
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = (state_q == PRE) || (state_q == WAIT_TRIG) || (state_q == POST);
  assign done      = (state_q == DONE);
  assign trig_addr = trig_addr_q;
endmodule

// File: tb/tb_snap_ring_capture.sv
// tb_snap_ring_capture: directed self-checking bench for snap_ring_capture at default parameters
module tb_snap_ring_capture;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] din = '0;
  logic         din_valid = 1'b0;
  logic         arm = 1'b0;
  logic         trig = 1'b0;
  logic [9:0]   pretrig_len = '0;
  logic         rd_en = 1'b0;
  logic [11:0]  rd_addr = '0;
  logic [31:0]  rd_data;
  logic         rd_valid;
  logic         busy;
  logic         done;
  logic [9:0]   trig_addr;
  int           n_chk = 0;
  int           n_fail = 0;
`ifdef SNAP_TRIG_TIME_EN
  logic [31:0]  trig_time;
  int           cyc = 0;
  int           exp_tt = 0;
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;
`endif
  always #5 clk = ~clk;
  snap_ring_capture dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .arm(arm), .trig(trig),
    .pretrig_len(pretrig_len), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .trig_addr(trig_addr)
`ifdef SNAP_TRIG_TIME_EN
    , .trig_time(trig_time)
`endif
  );
  function automatic logic [127:0] mk(int i);
    return {32'h3000_0000 | 32'(i), 32'h2000_0000 | 32'(i), 32'h1000_0000 | 32'(i), 32'(i)};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_arm(int p);
    arm = 1'b1;
    pretrig_len = 10'(p);
    tick();
    arm = 1'b0;
  endtask
  task automatic feed(int i, bit t);
    din = mk(i);
    din_valid = 1'b1;
    trig = t;
    tick();
    din_valid = 1'b0;
    trig = 1'b0;
  endtask
  task automatic rd(string tag, int addr, logic [31:0] exp);
    rd_en = 1'b1;
    rd_addr = 12'(addr);
    tick();
    rd_en = 1'b0;
    chk({tag, "_lat"}, rd_valid, 1'b0);
    tick();
    chk({tag, "_vld"}, rd_valid, 1'b1);
    chk(tag, rd_data, exp);
    tick();
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_rdd", rd_data, 0);
    chk("rst_taddr", trig_addr, 0);
    rst_n = 1'b1;
    tick();
    // P = 0, trigger on first valid sample
    do_arm(0);
    chk("p0_busy", busy, 1);
    tick();
`ifdef SNAP_TRIG_TIME_EN
    exp_tt = cyc;
`endif
    feed(0, 1);
`ifdef SNAP_TRIG_TIME_EN
    chk("trig_time", trig_time, 32'(exp_tt));
`endif
    for (int i = 1; i < 1023; i++) feed(i, 0);
    chk("p0_notdone", done, 0);
    feed(1023, 0);
    chk("p0_done", done, 1);
    chk("p0_idle", busy, 0);
    chk("p0_taddr", trig_addr, 0);
    feed(9999, 1);
    rd("p0_w0", 0, 32'd0);
    rd("p0_w4", 4, 32'd1);
    rd("p0_w7", 7, 32'h3000_0001);
    rd("p0_wlast", 4095, 32'h3000_03FF);
    rd_en = 1'b1; rd_addr = 12'd1; tick();
    rd_addr = 12'd2; tick();
    rd_en = 1'b0;
    chk("b2b_v1", rd_valid, 1);
    chk("b2b_d1", rd_data, 32'h1000_0000);
    tick();
    chk("b2b_v2", rd_valid, 1);
    chk("b2b_d2", rd_data, 32'h2000_0000);
    tick();
    chk("b2b_end", rd_valid, 0);
    // P = 100, trigger at sample 1500
    do_arm(100);
    chk("p100_done_clr", done, 0);
    chk("p100_busy", busy, 1);
    for (int i = 0; i < 2423; i++) feed(i, i == 1500);
    chk("p100_notdone", done, 0);
    feed(2423, 0);
    chk("p100_done", done, 1);
    chk("p100_taddr", trig_addr, 10'd476);
    rd("p100_s0", 0, 32'd1400);
    rd("p100_s100", 400, 32'd1500);
    rd("p100_s1023", 4092, 32'd2423);
    rd("p100_s1023l2", 4094, 32'h2000_0000 | 32'd2423);
    // P = 10 with trig held high through PRE
    do_arm(10);
    for (int i = 0; i < 10; i++) feed(i, 1);
    chk("p10_busy", busy, 1);
    chk("p10_oldtaddr", trig_addr, 10'd476);
    feed(10, 1);
    chk("p10_taddr", trig_addr, 10'd10);
    for (int i = 11; i < 1024; i++) feed(i, 0);
    chk("p10_done", done, 1);
    rd("p10_s10", 40, 32'd10);
    rd("p10_s0", 0, 32'd0);
    // trig only while din_valid is low
    do_arm(0);
    tick();
    for (int k = 0; k < 6; k++) begin
      feed(k, 0);
      trig = 1'b1;
      tick();
      trig = 1'b0;
    end
    chk("tgl_busy", busy, 1);
    chk("tgl_done", done, 0);
    chk("tgl_taddr", trig_addr, 10'd10);
    // reset during POST, with a read in flight
    do_arm(0);
    tick();
    feed(0, 1);
    for (int i = 1; i < 300; i++) feed(i, 0);
    chk("post_busy", busy, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    rst_n = 1'b0;
    din = '1;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rdv", rd_valid, 0);
    chk("mid_rst_taddr", trig_addr, 0);
    rst_n = 1'b1;
    tick();
    // capture after reset, P = 5
    do_arm(5);
    for (int j = 0; j < 1024; j++) feed(4096 + j, j == 5);
    chk("p5_done", done, 1);
    chk("p5_taddr", trig_addr, 10'd5);
    rd("p5_s0", 0, 32'd4096);
    rd("p5_s1023l1", 4093, 32'h1000_0000 | 32'(4096 + 1023));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
